// File: rtl/ir_frame_decoder_if.sv
// Bus between the IR frame decoder and the command dispatcher: raw receiver
// input in, decoded frame word and one-cycle strobes out.
interface ir_frame_decoder_if #(
    parameter int NBITS = 32
);
    logic             ir_input;
    logic [NBITS-1:0] ir_data;
    logic             ir_valid;
    logic             ir_repeat;
    logic             ir_err;
    logic             ir_busy;

    modport master (
        input  ir_input,
        output ir_data, ir_valid, ir_repeat, ir_err, ir_busy
    );

    modport slave (
        output ir_input,
        input  ir_data, ir_valid, ir_repeat, ir_err, ir_busy
    );
endinterface

// File: rtl/ir_frame_decoder.sv
// Pulse-distance IR frame decoder: measures space lengths on a divided tick and
// assembles NBITS-bit frames. Define IR_REPEAT_EN to build repeat-marker support.
//
// state | meaning
// IDLE  | waiting for a header space; repeat markers handled here
// RECV  | header seen, collecting data bits
module ir_frame_decoder #(
    parameter int TICK_DIV  = 1388,
    parameter int NBITS     = 32,
    parameter int LSB_FIRST = 1,
    parameter int BIT_MAX   = 64,
    parameter int ONE_THR   = 32,
    parameter int HDR_MIN   = 128
) (
    input logic              clk,
    input logic              reset,
    ir_frame_decoder_if.master bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;
    localparam logic [5:0] LAST_BIT = 6'(NBITS - 1);

    logic [1:0]       sync_ff;
    logic             ir_sync;
    logic [TW-1:0]    tick_cnt;
    logic             tick;
    logic             ir_prev;
    logic             fe;
    logic [7:0]       len_cnt;
    logic [0:0]       state;
    logic [5:0]       bit_cnt;
    logic [NBITS-2:0] sreg;
    logic [NBITS-2:0] sreg_next;
    logic [NBITS-1:0] word_next;
    logic             bit_in;
    logic             is_hdr;
    logic             is_bit;
`ifdef IR_REPEAT_EN
    logic             is_rpt;
    logic             have_frame;
`endif

    assign ir_sync = sync_ff[1];
    assign tick    = (tick_cnt == TW'(TICK_DIV - 1));
    assign fe      = tick & ir_prev & ~ir_sync;
    assign bit_in  = (len_cnt > 8'(ONE_THR));
    assign is_hdr  = (len_cnt >= 8'(HDR_MIN));
    assign is_bit  = (len_cnt < 8'(BIT_MAX));
`ifdef IR_REPEAT_EN
    assign is_rpt  = ~is_hdr & ~is_bit;
`else
    assign bus.ir_repeat = 1'b0;
`endif
    assign bus.ir_busy = (state == RECV);

    // sreg keeps only the NBITS-1 bits already received; the final bit is
    // merged straight into the output word.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign word_next = {bit_in, sreg};
            assign sreg_next = word_next[NBITS-1:1];
        end else begin : g_msb_first
            assign word_next = {sreg, bit_in};
            assign sreg_next = word_next[NBITS-2:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff      <= 2'b11;
            tick_cnt     <= '0;
            ir_prev      <= 1'b1;
            len_cnt      <= '0;
            state        <= IDLE;
            bit_cnt      <= '0;
            sreg         <= '0;
            bus.ir_data  <= '0;
            bus.ir_valid <= 1'b0;
            bus.ir_err   <= 1'b0;
`ifdef IR_REPEAT_EN
            bus.ir_repeat <= 1'b0;
            have_frame    <= 1'b0;
`endif
        end else begin
            sync_ff      <= {sync_ff[0], bus.ir_input};
            tick_cnt     <= tick ? '0 : tick_cnt + 1'b1;
            bus.ir_valid <= 1'b0;
            bus.ir_err   <= 1'b0;
`ifdef IR_REPEAT_EN
            bus.ir_repeat <= 1'b0;
`endif
            if (tick)
                ir_prev <= ir_sync;

            if (fe)
                len_cnt <= '0;
            else if (tick && ir_sync && len_cnt != 8'hFF)
                len_cnt <= len_cnt + 8'd1;

            if (fe) begin
                if (is_hdr) begin
                    sreg    <= '0;
                    bit_cnt <= '0;
                    if (state == RECV)
                        bus.ir_err <= 1'b1;
                    state <= RECV;
                end else if (state == RECV) begin
                    if (is_bit) begin
                        sreg    <= sreg_next;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == LAST_BIT) begin
                            bus.ir_data  <= word_next;
                            bus.ir_valid <= 1'b1;
                            state        <= IDLE;
`ifdef IR_REPEAT_EN
                            have_frame   <= 1'b1;
`endif
                        end
                    end else begin
                        bus.ir_err <= 1'b1;
                        state      <= IDLE;
`ifdef IR_REPEAT_EN
                        have_frame <= 1'b0;
`endif
                    end
                end
`ifdef IR_REPEAT_EN
                else if (is_rpt && have_frame) begin
                    bus.ir_repeat <= 1'b1;
                end
`endif
            end else if (state == RECV && len_cnt == 8'hFF) begin
                // Space never ended: abandon the frame once.
                bus.ir_err <= 1'b1;
                state      <= IDLE;
`ifdef IR_REPEAT_EN
                have_frame <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_ir_frame_decoder.sv
// Scoreboard bench for ir_frame_decoder with TICK_DIV=4; stimulus is spaces in ticks.
module tb_ir_frame_decoder;
    localparam int TD   = 4;
    localparam int MARK = 8;
    localparam logic [1:0] K_VALID = 2'd0, K_REPEAT = 2'd1, K_ERR = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    ir_frame_decoder_if #(.NBITS(32)) bus ();

    ir_frame_decoder #(
        .TICK_DIV(TD), .NBITS(32), .LSB_FIRST(1),
        .BIT_MAX(64), .ONE_THR(32), .HDR_MIN(128)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic expect_strobe(input logic [1:0] kind, input logic [31:0] data, input logic busy);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.busy = busy;
        exp_q.push_back(e);
    endtask

    // High for n ticks, then a low mark; the falling edge ends the space.
    task automatic space(input int n);
        bus.ir_input = 1'b1;
        repeat (n * TD) @(negedge clk);
        bus.ir_input = 1'b0;
        repeat (MARK * TD) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] d, input int nb);
        logic [31:0] w;
        w = d;
        for (int i = 0; i < nb; i++)
            space(w[i] ? 60 : 20);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && (bus.ir_valid || bus.ir_repeat || bus.ir_err)) begin
            logic [1:0] kind;
            exp_t e;
            check("strobe_onehot", 32'(bus.ir_valid) + 32'(bus.ir_repeat) + 32'(bus.ir_err), 32'd1);
            kind = bus.ir_valid ? K_VALID : (bus.ir_repeat ? K_REPEAT : K_ERR);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe_kind", 32'(kind), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", 32'(kind), 32'(e.kind));
                check("strobe_data", bus.ir_data, e.data);
                check("strobe_busy", 32'(bus.ir_busy), 32'(e.busy));
            end
        end
    end

    initial begin
        bus.ir_input = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data",   bus.ir_data, 32'h0);
        check("rst_valid",  32'(bus.ir_valid), 32'h0);
        check("rst_repeat", 32'(bus.ir_repeat), 32'h0);
        check("rst_err",    32'(bus.ir_err), 32'h0);
        check("rst_busy",   32'(bus.ir_busy), 32'h0);
        reset = 1'b0;

        // Full frame 0x5DA2FF00 LSB-first
        space(160);
        check("busy_after_header", 32'(bus.ir_busy), 32'h1);
        expect_strobe(K_VALID, 32'h5DA2FF00, 1'b0);
        send_bits(32'h5DA2FF00, 32);
        check("busy_after_frame", 32'(bus.ir_busy), 32'h0);

        // Repeat marker after a good frame
`ifdef IR_REPEAT_EN
        expect_strobe(K_REPEAT, 32'h5DA2FF00, 1'b0);
`endif
        space(90);

        // Timeout after 10 bits. The fall that ends the long high is itself
        // a header, so the following 90-tick space aborts inside RECV; a second
        // 90 in IDLE must not repeat because have_frame was cleared.
        space(160);
        send_bits(32'h0000_02B5, 10);
        expect_strobe(K_ERR, 32'h5DA2FF00, 1'b0);
        bus.ir_input = 1'b1;
        repeat (300 * TD) @(negedge clk);
        check("queue_after_timeout", 32'(exp_q.size()), 32'd0);
        bus.ir_input = 1'b0;
        repeat (MARK * TD) @(negedge clk);
        check("busy_after_long_header", 32'(bus.ir_busy), 32'h1);
        expect_strobe(K_ERR, 32'h5DA2FF00, 1'b0);
        space(90);
        space(90);
        check("queue_after_no_repeat", 32'(exp_q.size()), 32'd0);

        // Header restart mid-frame, then a full frame
        space(160);
        send_bits(32'h0000_0015, 5);
        expect_strobe(K_ERR, 32'h5DA2FF00, 1'b1);
        space(160);
        expect_strobe(K_VALID, 32'h12345678, 1'b0);
        send_bits(32'h12345678, 32);

        // Reset after 16 bits, then a repeat-length space and a fresh frame
        space(160);
        send_bits(32'h0000_C3A5, 16);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst2_data", bus.ir_data, 32'h0);
        check("rst2_busy", 32'(bus.ir_busy), 32'h0);
        reset = 1'b0;
        space(90);
        check("queue_after_reset_space", 32'(exp_q.size()), 32'd0);
        space(160);
        expect_strobe(K_VALID, 32'hA5C30F96, 1'b0);
        send_bits(32'hA5C30F96, 32);

        repeat (50) @(negedge clk);
        check("final_data", bus.ir_data, 32'hA5C30F96);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
